// File: rtl/bpsk_word_link.sv
// rtl/bpsk_word_link.sv - BPSK word link: serialiser, noise adder, slicer, reassembly
// Optional bit-error counter enabled by defining BPSK_BIT_ERR_CNT_EN.

module bpsk_word_link #(
    parameter int DATA_W = 24,
    parameter int LANES  = 1,
    parameter int SYM_W  = 25,
    parameter int AMP    = 2**(SYM_W-2)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [LANES*SYM_W-1:0]   noise,
    output logic [LANES*SYM_W-1:0]   sym_out,
    output logic                     sym_valid,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     err_clr,
    output logic [15:0]              err_cnt
);
    localparam int BEATS = DATA_W / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0]           LAST_BEAT = BW'(BEATS - 1);
    localparam logic [SYM_W-1:0]        SYM_POS   = SYM_W'(AMP);
    localparam logic [SYM_W-1:0]        SYM_NEG   = SYM_W'(-AMP);
    localparam logic signed [SYM_W-1:0] SAT_MAX   = {1'b0, {(SYM_W-1){1'b1}}};
    localparam logic signed [SYM_W-1:0] SAT_MIN   = {1'b1, {(SYM_W-1){1'b0}}};

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state;
    logic [BW-1:0]     beat;
    logic [DATA_W-1:0] tx_word;
    logic [DATA_W-1:0] rx_word;
    logic [DATA_W-1:0] rx_done;
    logic [LANES-1:0]  dec_bits;
    logic [LANES-1:0]  next_bits;
    logic [IW-1:0]     cur_idx;
    logic [IW-1:0]     next_idx;

    function automatic logic [LANES*SYM_W-1:0] map_syms(input logic [LANES-1:0] bits);
        logic [LANES*SYM_W-1:0] m;
        for (int k = 0; k < LANES; k++) begin
            m[k*SYM_W +: SYM_W] = bits[k] ? SYM_POS : SYM_NEG;
        end
        return m;
    endfunction

    // One extra bit of headroom makes the overflow check a simple sign-bit compare.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [SYM_W-1:0] sym;
        logic signed [SYM_W-1:0] nse;
        logic signed [SYM_W:0]   sum;
        logic signed [SYM_W-1:0] sat;
        assign sym = sym_out[k*SYM_W +: SYM_W];
        assign nse = noise[k*SYM_W +: SYM_W];
        assign sum = {sym[SYM_W-1], sym} + {nse[SYM_W-1], nse};
        assign sat = (sum[SYM_W] != sum[SYM_W-1]) ? (sum[SYM_W] ? SAT_MIN : SAT_MAX)
                                                  : sum[SYM_W-1:0];
        assign dec_bits[k] = (sat >= 0);
    end

    always_comb begin
        cur_idx   = IW'(int'(beat) * LANES);
        next_idx  = IW'((int'(beat) + 1) * LANES);
        next_bits = '0;
        if (beat != LAST_BEAT) begin
            next_bits = tx_word[next_idx +: LANES];
        end
        rx_done = rx_word;
        rx_done[cur_idx +: LANES] = dec_bits;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            beat      <= '0;
            tx_word   <= '0;
            rx_word   <= '0;
            in_ready  <= 1'b0;
            sym_out   <= '0;
            sym_valid <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        tx_word   <= in_data;
                        beat      <= '0;
                        state     <= SEND;
                        in_ready  <= 1'b0;
                        sym_out   <= map_syms(in_data[LANES-1:0]);
                        sym_valid <= 1'b1;
                    end
                end
                SEND: begin
                    rx_word[cur_idx +: LANES] <= dec_bits;
                    if (beat == LAST_BEAT) begin
                        out_data  <= rx_done;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                        sym_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end else begin
                        beat    <= beat + BW'(1);
                        sym_out <= map_syms(next_bits);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BPSK_BIT_ERR_CNT_EN
    localparam int CW = $clog2(LANES + 1);
    logic [LANES-1:0] cur_bits;
    logic [CW-1:0]    n_err;
    logic [16:0]      err_sum;

    assign cur_bits = tx_word[cur_idx +: LANES];

    always_comb begin
        n_err = '0;
        for (int k = 0; k < LANES; k++) begin
            n_err = n_err + CW'(dec_bits[k] ^ cur_bits[k]);
        end
        err_sum = {1'b0, err_cnt} + 17'(n_err);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (state == SEND) begin
            err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_cnt        = '0;
`endif

endmodule

// File: doc/bpsk_word_link.md
Name: bpsk_word_link

Overview:
- Parametrised next-generation transmit/receive link for the AWGN channel test harness.
- Accepts a DATA_W-bit word over a valid/ready handshake and serialises it LANES bits per cycle.
- Maps each bit to a signed SYM_W-bit antipodal symbol and adds externally supplied noise per lane with saturation.
- Hard-slices each noisy symbol, reassembles the word, emits it with a valid pulse, and optionally counts bit errors.

Parameters:
- DATA_W, 24: payload word width; must be divisible by LANES.
- LANES, 1: bits (symbols) transmitted per cycle.
- SYM_W, 25: signed symbol width in bits.
- AMP, 2**(SYM_W-2): symbol magnitude; bit 1 maps to +AMP, bit 0 maps to -AMP. Must be less than 2**(SYM_W-1).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_W  payload word.
- noise  in  LANES*SYM_W  signed noise per lane; lane k occupies bits [k*SYM_W +: SYM_W].
- sym_out  out  LANES*SYM_W  registered transmit symbols, noise-free, for observation.
- sym_valid  out  1  sym_out holds a live beat.
- out_valid  out  1  one-cycle pulse; out_data is valid while high.
- out_data  out  DATA_W  reassembled received word.
- err_clr  in  1  synchronous clear of err_cnt.
- err_cnt  out  16  saturating bit-error count.

Behaviour:
- BEATS = DATA_W/LANES. FSM states: IDLE, SEND.
- Reset: state IDLE, beat counter 0, and every output cleared: in_ready=0, sym_out=0, sym_valid=0, out_valid=0, out_data=0, err_cnt=0. in_ready rises to 1 in the first cycle after reset deasserts, with the FSM in IDLE.
- Reset has priority over all other inputs. Reset during SEND discards the partial word and emits no out_valid.
- IDLE: in_ready=1. On an edge where in_valid=1, latch in_data into the tx register, set beat=0, and go to SEND.
- SEND: in_ready=0; in_valid is ignored.
  - Beat b transmits bits [b*LANES +: LANES], LSB first. Lane k carries bit b*LANES+k.
  - sym_out and sym_valid are registered: they are updated on the accept edge and on each beat edge, so they show beat b during beat b's cycle.
- Channel, combinational per lane: sum = sym + noise, computed at SYM_W+1 bits.
  - Saturate the sum to the signed SYM_W range: clamp to +(2**(SYM_W-1)-1) or -(2**(SYM_W-1)).
- Slicer: decided bit = 1 if the saturated sum is >= 0, else 0. Decided bits are written into rx word positions [b*LANES +: LANES] on the beat edge.
- On the edge closing beat BEATS-1:
  - out_data takes the complete rx word; out_valid=1 for exactly the following cycle.
  - State returns to IDLE; sym_valid=0.
- Latency: accept edge E0; out_valid is high in the cycle after edge E0+BEATS.
- Back-to-back: a new word may be accepted in the same cycle out_valid is high, so throughput is one word per BEATS+1 cycles.
- out_data holds its value until the next completion or a reset.

Optional Feature:
- Macro: BPSK_BIT_ERR_CNT_EN.
- Defined:
  - On each beat edge, err_cnt increments by the number of lanes whose decided bit differs from the transmitted bit.
  - err_cnt saturates at 16'hFFFF.
  - err_clr=1 clears err_cnt to 0 and takes priority over an increment on the same edge.
  - The count persists across words.
- Undefined: err_cnt is tied to 0, err_clr is ignored, and no comparison logic is built. Port list is unchanged.

Test Plan:
1. Clean link: DATA_W=24, LANES=1, noise=0, send 24'hA5A5A5 -> out_valid high exactly 25 cycles after the accept edge, out_data=24'hA5A5A5, err_cnt=0.
2. Inverting noise: all noise = -(AMP+1), send 24'hFFFFFF -> out_data=24'h000000; err_cnt=24 with the macro defined, 0 without it.
3. Saturation: noise = +(2**24-1) on all lanes, send 24'hFFFFFF -> sums clamp to 2**24-1 with no wrap, out_data=24'hFFFFFF. Noise = -AMP exactly with bit 1 gives a sum of 0, which slices to 1.
4. Multi-lane: LANES=4, send 24'h123456 -> sym_valid high for 6 cycles, out_valid 7 cycles after accept, out_data=24'h123456.
5. Reset mid-word: assert reset at beat 10 -> no out_valid, all outputs 0. Next word 24'h00FF00 is received correctly.
6. Counter control: 3 words of 24 errors each -> err_cnt=72. Pulse err_clr on the same edge as an error beat -> err_cnt=0. Preload to 16'hFFFE, then 24 more errors -> err_cnt holds at 16'hFFFF.
